// File: rtl/and_sweep_sequencer_pkg.sv
// rtl/and_sweep_sequencer_pkg.sv - shared state encoding and sizing helpers for the AND sweep sequencer
package and_sweep_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } sweep_state_e;

    // Dwell counter needs at least one bit even when every vector is held a single cycle.
    function automatic int unsigned dw_width(input int unsigned dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/and_sweep_sequencer_vec_counter.sv
// rtl/and_sweep_sequencer_vec_counter.sv - vector and dwell counters with last-vector and compare-strobe flags
module and_sweep_sequencer_vec_counter
    import and_sweep_sequencer_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               run,
    output logic [2*WIDTH-1:0] vec,
    output logic               last_vec,
    output logic               cmp_strobe
);

    localparam int unsigned VW   = 2 * WIDTH;
    localparam int unsigned DW_W = dw_width(DWELL);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

    logic [VW-1:0]   vec_q, vec_d;
    logic [DW_W-1:0] dw_q, dw_d;

    assign vec        = vec_q;
    assign last_vec   = &vec_q;
    assign cmp_strobe = (dw_q == DW_LAST);

    // On the last vector the counters freeze; the sequencer leaves RUN on that strobe.
    always_comb begin
        vec_d = vec_q;
        dw_d  = dw_q;
        if (load) begin
            vec_d = '0;
            dw_d  = '0;
        end else if (run) begin
            if (!cmp_strobe) begin
                dw_d = dw_q + DW_W'(1);
            end else if (!last_vec) begin
                vec_d = vec_q + VW'(1);
                dw_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_q <= '0;
            dw_q  <= '0;
        end else begin
            vec_q <= vec_d;
            dw_q  <= dw_d;
        end
    end

endmodule

// File: rtl/and_sweep_sequencer.sv
// rtl/and_sweep_sequencer.sv - sweeps {a,b} over all vectors, checks dut_out against a & b; SWEEP_ERR_LOG_EN adds a first-mismatch log
module and_sweep_sequencer
    import and_sweep_sequencer_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] drv_a,
    output logic [WIDTH-1:0] drv_b,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count
`ifdef SWEEP_ERR_LOG_EN
    ,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b
`endif
);

    sweep_state_e     state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic [2*WIDTH-1:0] vec;
    logic               last_vec;
    logic               cmp_strobe;
    logic               load;
    logic               run;
    logic               mismatch;

    assign load     = (state_q == ST_IDLE) && start;
    assign run      = (state_q == ST_RUN);
    assign drv_a    = vec[2*WIDTH-1:WIDTH];
    assign drv_b    = vec[WIDTH-1:0];
    assign mismatch = (dut_out != (drv_a & drv_b));

    and_sweep_sequencer_vec_counter #(
        .WIDTH (WIDTH),
        .DWELL (DWELL)
    ) u_vec_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .run        (run),
        .vec        (vec),
        .last_vec   (last_vec),
        .cmp_strobe (cmp_strobe)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                end
            end
            ST_RUN: begin
                if (cmp_strobe) begin
                    if (mismatch && (err_q != '1)) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    // pass must include the final compare, so it uses the updated count.
                    if (last_vec) begin
                        state_d = ST_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

`ifdef SWEEP_ERR_LOG_EN
    logic             fe_valid_q, fe_valid_d;
    logic [WIDTH-1:0] fe_a_q, fe_a_d;
    logic [WIDTH-1:0] fe_b_q, fe_b_d;

    assign first_err_valid = fe_valid_q;
    assign first_err_a     = fe_a_q;
    assign first_err_b     = fe_b_q;

    always_comb begin
        fe_valid_d = fe_valid_q;
        fe_a_d     = fe_a_q;
        fe_b_d     = fe_b_q;
        if (load) begin
            fe_valid_d = 1'b0;
            fe_a_d     = '0;
            fe_b_d     = '0;
        end else if (run && cmp_strobe && mismatch && !fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_a_d     = drv_a;
            fe_b_d     = drv_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fe_valid_q <= 1'b0;
            fe_a_q     <= '0;
            fe_b_q     <= '0;
        end else begin
            fe_valid_q <= fe_valid_d;
            fe_a_q     <= fe_a_d;
            fe_b_q     <= fe_b_d;
        end
    end
`endif

endmodule
